// File: rtl/serial_pkg.sv
// ============================================================================
// serial_pkg : shared UART constants and FSM state encoding (rx and tx paths)
// Revision   : 1.0
// ============================================================================
`default_nettype none

package serial_pkg;

    localparam int UART_DATA_BITS = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// sync_2ff : two-flop synchroniser for asynchronous pins, resets to idle-high
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int   WIDTH     = 1,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= {WIDTH{RESET_VAL}};
            r_sync <= {WIDTH{RESET_VAL}};
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/serial_rx.sv
// ============================================================================
// serial_rx : 8N1 UART receiver with valid/ready byte output and error pulses
// Revision  : 1.0
// ============================================================================
`default_nettype none

module serial_rx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk0,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] c_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [2:0]       c_IDX_LAST  = 3'(UART_DATA_BITS - 1);

    logic                      w_rx_s;
    logic [2:0]                r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [2:0]                r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;

    logic w_bit_end;
    logic w_half_end;
    logic w_stop_done;
    logic w_deliver;
    logic w_room;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk0),
        .rst (reset),
        .i_d (serial_in),
        .o_q (w_rx_s)
    );

    assign w_bit_end   = (r_cnt == c_BIT_LAST);
    assign w_half_end  = (r_cnt == c_HALF_LAST);
    assign w_stop_done = (r_state == ST_STOP) && w_bit_end;
    assign w_deliver   = w_stop_done && w_rx_s;
    // Holding register is free if empty or being drained on this same edge
    assign w_room      = !rx_valid || rx_ready;
    assign busy        = (r_state != ST_IDLE);

    always_ff @(posedge clk0 or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_s) begin
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_half_end) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= 3'd0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == c_IDX_LAST) begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= w_rx_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    // A held-low line parks here so it cannot re-trigger START
                    r_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk0 or posedge reset) begin
        if (reset) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= w_stop_done && !w_rx_s;
            overrun   <= w_deliver && !w_room;
            if (w_deliver && w_room) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_rx.sv
// ============================================================================
// tb_serial_rx : randomized self-checking bench for serial_rx (8 and 434 clk/bit)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_serial_rx;

    localparam int CPB      = 8;
    localparam int CPB_SLOW = 434;

    logic       clk0 = 1'b0;
    logic       reset = 1'b1;
    logic       serial_in = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;

    logic       serial_in2 = 1'b1;
    logic       rx_ready2 = 1'b1;
    logic [7:0] rx_data2;
    logic       rx_valid2, frame_err2, overrun2, busy2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int rise_cyc = 0;
    logic prev_valid = 1'b0;
    int valid_cycles = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int fe2_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] got2_q[$];

    always #5 clk0 = ~clk0;

    serial_rx #(.CLKS_PER_BIT(CPB)) u_dut (
        .clk0      (clk0),
        .reset     (reset),
        .serial_in (serial_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    serial_rx #(.CLKS_PER_BIT(CPB_SLOW)) u_dut_slow (
        .clk0      (clk0),
        .reset     (reset),
        .serial_in (serial_in2),
        .rx_data   (rx_data2),
        .rx_valid  (rx_valid2),
        .rx_ready  (rx_ready2),
        .frame_err (frame_err2),
        .overrun   (overrun2),
        .busy      (busy2)
    );

    always @(posedge clk0) cyc <= cyc + 1;

    // Observe on the falling edge: handshakes, rising valid, pulse counts
    always @(negedge clk0) begin
        if (rx_valid && !prev_valid) rise_cyc <= cyc;
        prev_valid <= rx_valid;
        if (rx_valid) valid_cycles <= valid_cycles + 1;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (overrun) ov_cnt <= ov_cnt + 1;
        if (rx_valid2 && rx_ready2) got2_q.push_back(rx_data2);
        if (frame_err2) fe2_cnt <= fe2_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk0);
            #1;
        end
    endtask

    task automatic drive_pin(input bit slow, input logic v);
        if (slow) serial_in2 = v;
        else serial_in = v;
    endtask

    // 8N1 frame, LSB first; k is the first edge that sees the falling start edge
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int period, input bit slow, output int k);
        k = cyc + 1;
        drive_pin(slow, 1'b0);
        tick(period);
        for (int i = 0; i < 8; i++) begin
            drive_pin(slow, b[i]);
            tick(period);
        end
        drive_pin(slow, stop_bit);
        tick(period);
        drive_pin(slow, 1'b1);
    endtask

    task automatic test_reset();
        int vc;
        tick(3);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%0h exp=00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%b%b exp=00", frame_err, overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b0;
        tick(2);
        serial_in = 1'b0;
        tick(20);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midstream_busy got=%b exp=1", busy); end
        #3 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 8'h00) begin
            errors++; $display("FAIL async_reset got busy=%b valid=%b data=%0h exp 0/0/00", busy, rx_valid, rx_data);
        end
        serial_in = 1'b1;
        tick(2);
        reset = 1'b0;
        vc = valid_cycles;
        tick(200);
        checks++; if (valid_cycles !== vc || busy !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset got valid_cycles=%0d busy=%b exp %0d/0", valid_cycles, busy, vc);
        end
    endtask

    task automatic test_latency(input logic [7:0] b);
        int k, vc, fe0, ov0;
        logic [7:0] g;
        rx_ready = 1'b1;
        got_q.delete();
        vc = valid_cycles; fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(b, 1'b1, CPB, 1'b0, k);
        tick(10);
        g = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        checks++; if (got_q.size() != 1 || g !== b) begin errors++; $display("FAIL lat_data got=%0h n=%0d exp=%0h", g, got_q.size(), b); end
        checks++; if (rise_cyc != k + 2 + CPB / 2 + 9 * CPB) begin
            errors++; $display("FAIL lat_edge got=%0d exp=%0d", rise_cyc - k, 2 + CPB / 2 + 9 * CPB);
        end
        checks++; if (valid_cycles - vc != 1) begin errors++; $display("FAIL lat_valid_width got=%0d exp=1", valid_cycles - vc); end
        checks++; if (fe_cnt != fe0 || ov_cnt != ov0) begin errors++; $display("FAIL lat_no_err got fe=%0d ov=%0d exp 0/0", fe_cnt - fe0, ov_cnt - ov0); end
    endtask

    task automatic test_glitch();
        int vc, fe0, ov0;
        vc = valid_cycles; fe0 = fe_cnt; ov0 = ov_cnt;
        serial_in = 1'b0;
        tick(3);
        serial_in = 1'b1;
        tick(1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_start got busy=%b exp=1", busy); end
        tick(40);
        checks++; if (busy !== 1'b0 || valid_cycles != vc || fe_cnt != fe0 || ov_cnt != ov0) begin
            errors++; $display("FAIL glitch_reject got busy=%b valid=%0d fe=%0d ov=%0d exp 0/0/0/0",
                                busy, valid_cycles - vc, fe_cnt - fe0, ov_cnt - ov0);
        end
    endtask

    task automatic test_frame_error();
        int k, vc, fe0;
        logic [7:0] g;
        vc = valid_cycles; fe0 = fe_cnt;
        got_q.delete();
        send_frame(8'h3C, 1'b0, CPB, 1'b0, k);
        serial_in = 1'b0;
        tick(40);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy got=%b exp=1", busy); end
        checks++; if (fe_cnt - fe0 != 1 || valid_cycles != vc) begin
            errors++; $display("FAIL frame_err got fe=%0d valid=%0d exp 1/0", fe_cnt - fe0, valid_cycles - vc);
        end
        serial_in = 1'b1;
        tick(10);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_exit got busy=%b exp=0", busy); end
        send_frame(8'h11, 1'b1, CPB, 1'b0, k);
        tick(10);
        g = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        checks++; if (got_q.size() != 1 || g !== 8'h11 || fe_cnt - fe0 != 1) begin
            errors++; $display("FAIL after_break got=%0h n=%0d fe=%0d exp 11/1/1", g, got_q.size(), fe_cnt - fe0);
        end
    endtask

    task automatic test_overrun();
        int k, ov0;
        logic [7:0] g;
        rx_ready = 1'b0;
        got_q.delete();
        ov0 = ov_cnt;
        send_frame(8'h01, 1'b1, CPB, 1'b0, k);
        send_frame(8'h02, 1'b1, CPB, 1'b0, k);
        tick(10);
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h01) begin
            errors++; $display("FAIL ovr_hold got valid=%b data=%0h exp 1/01", rx_valid, rx_data);
        end
        checks++; if (ov_cnt - ov0 != 1 || got_q.size() != 0) begin
            errors++; $display("FAIL ovr_pulse got ov=%0d taken=%0d exp 1/0", ov_cnt - ov0, got_q.size());
        end
        rx_ready = 1'b1;
        tick(2);
        g = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        checks++; if (rx_valid !== 1'b0 || got_q.size() != 1 || g !== 8'h01) begin
            errors++; $display("FAIL ovr_accept got valid=%b data=%0h n=%0d exp 0/01/1", rx_valid, g, got_q.size());
        end
    endtask

    task automatic test_reset_mid_data();
        int k, fe0, ov0;
        logic [7:0] g;
        got_q.delete();
        fe0 = fe_cnt; ov0 = ov_cnt;
        serial_in = 1'b0;
        tick(CPB);
        serial_in = 1'b1;
        tick(4 * CPB + CPB / 2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_data_busy got=%b exp=1", busy); end
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin
            errors++; $display("FAIL mid_data_reset got busy=%b valid=%b exp 0/0", busy, rx_valid);
        end
        tick(2);
        reset = 1'b0;
        tick(20);
        send_frame(8'h5A, 1'b1, CPB, 1'b0, k);
        tick(10);
        g = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        checks++; if (got_q.size() != 1 || g !== 8'h5A || fe_cnt != fe0 || ov_cnt != ov0) begin
            errors++; $display("FAIL after_mid_reset got=%0h n=%0d fe=%0d ov=%0d exp 5a/1/0/0",
                                g, got_q.size(), fe_cnt - fe0, ov_cnt - ov0);
        end
    endtask

    task automatic test_random_stream();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int k;
        rx_ready = 1'b1;
        got_q.delete();
        for (int n = 0; n < 10; n++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1, CPB, 1'b0, k);
            tick($urandom_range(0, 12));
        end
        tick(10);
        checks++; if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rand_byte[%0d] got=%0h exp=%0h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_slow_baud();
        int k;
        logic [7:0] g;
        got2_q.delete();
        // Transmitter about 3% fast relative to the 434-clock receiver
        send_frame(8'hA5, 1'b1, 421, 1'b1, k);
        tick(300);
        g = (got2_q.size() > 0) ? got2_q[0] : 8'hxx;
        checks++; if (got2_q.size() != 1 || g !== 8'hA5 || fe2_cnt != 0) begin
            errors++; $display("FAIL slow_baud got=%0h n=%0d fe=%0d exp a5/1/0", g, got2_q.size(), fe2_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_latency(8'hA5);
        test_glitch();
        test_frame_error();
        test_overrun();
        test_reset_mid_data();
        test_random_stream();
        test_slow_baud();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

`default_nettype wire
